// File: rtl/mfp_bot_updt_handshake_if.sv
// Bot update handshake bundle between the Rojobot update source, the CPU I/O block and this bridge.
// fsm_state mirrors the bridge FSM (1 = PENDING) for observation.
interface mfp_bot_updt_handshake_if #(
  parameter int INFO_W = 32,
  parameter int MISS_W = 8,
  parameter int CNT_W  = 16
);
  logic              BotUpd_Raw;
  logic [INFO_W-1:0] BotInfo_Raw;
  logic              IO_INT_ACK;
  logic              Clr_Ovr;
  logic              IO_BotUpdt_Sync;
  logic [INFO_W-1:0] IO_BotInfo;
  logic [MISS_W-1:0] Missed_Cnt;
  logic              Overrun;
  logic [CNT_W-1:0]  Updt_Cnt;
  logic              fsm_state;

  modport master (
    output BotUpd_Raw, BotInfo_Raw, IO_INT_ACK, Clr_Ovr,
    input  IO_BotUpdt_Sync, IO_BotInfo, Missed_Cnt, Overrun, Updt_Cnt, fsm_state
  );

  modport slave (
    input  BotUpd_Raw, BotInfo_Raw, IO_INT_ACK, Clr_Ovr,
    output IO_BotUpdt_Sync, IO_BotInfo, Missed_Cnt, Overrun, Updt_Cnt, fsm_state
  );
endinterface

// File: rtl/mfp_bot_updt_handshake.sv
// Synchronises the bot update strobe, snapshots the bot info word and holds an update-pending
// flag until the CPU acknowledges; late acknowledges are counted as overruns.
module mfp_bot_updt_handshake #(
  parameter int SYNC_STAGES = 2,
  parameter int INFO_W      = 32,
  parameter int MISS_W      = 8,
  parameter int CNT_W       = 16
) (
  input logic HCLK,
  input logic HRESETn,
  mfp_bot_updt_handshake_if.slave bus
);

  // Handshake: evt (one cycle per BotUpd_Raw rise) sets the pending flag; IO_INT_ACK clears it
  // only while pending. An ack in the same cycle as a new evt consumes the old data, so no miss.
  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t             state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               sync_out;
  logic               sync_out_d;
  logic               evt;
  logic               miss;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign evt      = sync_out & ~sync_out_d;
  assign miss     = (state == PENDING) & evt & ~bus.IO_INT_ACK;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_q     <= '0;
      sync_out_d <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.BotUpd_Raw};
      sync_out_d <= sync_out;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state               <= IDLE;
      bus.IO_BotUpdt_Sync <= 1'b0;
      bus.IO_BotInfo      <= '0;
      bus.Updt_Cnt        <= '0;
      bus.Missed_Cnt      <= '0;
      bus.Overrun         <= 1'b0;
    end else begin
      if (evt) begin
        bus.IO_BotInfo <= bus.BotInfo_Raw;
        bus.Updt_Cnt   <= bus.Updt_Cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (evt) begin
            state               <= PENDING;
            bus.IO_BotUpdt_Sync <= 1'b1;
          end
        end
        PENDING: begin
          if (!evt && bus.IO_INT_ACK) begin
            state               <= IDLE;
            bus.IO_BotUpdt_Sync <= 1'b0;
          end
        end
        default: begin
          state               <= IDLE;
          bus.IO_BotUpdt_Sync <= 1'b0;
        end
      endcase

      // A miss in the same cycle as Clr_Ovr restarts the count at one.
      if (bus.Clr_Ovr) begin
        bus.Missed_Cnt <= miss ? {{(MISS_W-1){1'b0}}, 1'b1} : '0;
        bus.Overrun    <= miss;
      end else if (miss) begin
        if (bus.Missed_Cnt != '1) bus.Missed_Cnt <= bus.Missed_Cnt + 1'b1;
        bus.Overrun <= 1'b1;
      end
    end
  end

  assign bus.fsm_state = (state == PENDING);

endmodule

// File: tb/tb_mfp_bot_updt_handshake.sv
// Directed plus randomized bench for mfp_bot_updt_handshake; a default-width and a narrow-counter
// instance share stimulus and are compared against one event-level reference model.
module tb_mfp_bot_updt_handshake;

  logic HCLK;
  logic HRESETn;

  mfp_bot_updt_handshake_if #(.INFO_W(32), .MISS_W(8), .CNT_W(16)) bif ();
  mfp_bot_updt_handshake_if #(.INFO_W(32), .MISS_W(2), .CNT_W(4))  bif_s ();

  assign bif_s.BotUpd_Raw  = bif.BotUpd_Raw;
  assign bif_s.BotInfo_Raw = bif.BotInfo_Raw;
  assign bif_s.IO_INT_ACK  = bif.IO_INT_ACK;
  assign bif_s.Clr_Ovr     = bif.Clr_Ovr;

  mfp_bot_updt_handshake #(.SYNC_STAGES(2), .INFO_W(32), .MISS_W(8), .CNT_W(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bif)
  );
  mfp_bot_updt_handshake #(.SYNC_STAGES(2), .INFO_W(32), .MISS_W(2), .CNT_W(4)) dut_s (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bif_s)
  );

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // reference model: pending flag, event totals and the snapshot history
  int          errors = 0;
  int          checks = 0;
  bit          m_pend;
  int          m_updt;
  int          m_miss;
  bit          m_ovr;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_info();
    return (exp_q.size() == 0) ? 32'h0 : exp_q[exp_q.size()-1];
  endfunction

  function automatic logic [31:0] sat(input int v, input int max);
    return 32'((v > max) ? max : v);
  endfunction

  task automatic model_reset();
    m_pend = 1'b0; m_updt = 0; m_miss = 0; m_ovr = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_evt(input logic [31:0] info, input bit ack, input bit clr);
    bit missed;
    missed = m_pend && !ack;
    if (clr) begin
      m_miss = missed ? 1 : 0;
      m_ovr  = missed;
    end else if (missed) begin
      m_miss++;
      m_ovr = 1'b1;
    end
    m_pend = 1'b1;
    m_updt++;
    exp_q.push_back(info);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".flag"},   32'(bif.IO_BotUpdt_Sync), 32'(m_pend));
    check({tag, ".state"},  32'(bif.fsm_state),       32'(m_pend));
    check({tag, ".info"},   bif.IO_BotInfo,           exp_info());
    check({tag, ".updt"},   32'(bif.Updt_Cnt),        32'(m_updt % 65536));
    check({tag, ".miss"},   32'(bif.Missed_Cnt),      sat(m_miss, 255));
    check({tag, ".ovr"},    32'(bif.Overrun),         32'(m_ovr));
    check({tag, ".s_updt"}, 32'(bif_s.Updt_Cnt),      32'(m_updt % 16));
    check({tag, ".s_miss"}, 32'(bif_s.Missed_Cnt),    sat(m_miss, 3));
    check({tag, ".s_info"}, bif_s.IO_BotInfo,         exp_info());
  endtask

  // driver tasks; all called at a negedge, outputs sampled at negedges
  task automatic evt_sequence(input logic [31:0] info, input bit ack, input bit clr, input bit chk_lat);
    bit old_pend;
    old_pend = m_pend;
    @(negedge HCLK);  // edge N sampled the strobe
    if (chk_lat) check("lat_n", 32'(bif.IO_BotUpdt_Sync), 32'(old_pend));
    @(negedge HCLK);  // edge N+1
    if (chk_lat) check("lat_n1", 32'(bif.IO_BotUpdt_Sync), 32'(old_pend));
    bif.IO_INT_ACK = ack;
    bif.Clr_Ovr    = clr;
    @(negedge HCLK);  // edge N+2: snapshot lands
    bif.IO_INT_ACK = 1'b0;
    bif.Clr_Ovr    = 1'b0;
    model_evt(info, ack, clr);
    check_outputs("evt");
    repeat (3) @(negedge HCLK);
    check_outputs("hold");
    bif.BotUpd_Raw = 1'b0;
    repeat (2) @(negedge HCLK);
  endtask

  task automatic bot_update(input logic [31:0] info, input bit ack, input bit clr, input bit chk_lat);
    bif.BotInfo_Raw = info;
    bif.BotUpd_Raw  = 1'b1;
    evt_sequence(info, ack, clr, chk_lat);
  endtask

  task automatic ack_pulse();
    bif.IO_INT_ACK = 1'b1;
    @(negedge HCLK);
    bif.IO_INT_ACK = 1'b0;
    m_pend = 1'b0;
    check_outputs("ack");
  endtask

  task automatic clr_pulse();
    bif.Clr_Ovr = 1'b1;
    @(negedge HCLK);
    bif.Clr_Ovr = 1'b0;
    m_miss = 0;
    m_ovr  = 1'b0;
    check_outputs("clr");
  endtask

  task automatic async_reset(input bit raw_hi, input logic [31:0] info);
    #3 HRESETn = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    bif.BotInfo_Raw = info;
    bif.BotUpd_Raw  = raw_hi;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  initial begin
    logic [31:0] a, b, c;
    HRESETn         = 1'b0;
    bif.BotUpd_Raw  = 1'b0;
    bif.BotInfo_Raw = '0;
    bif.IO_INT_ACK  = 1'b0;
    bif.Clr_Ovr     = 1'b0;
    model_reset();
    repeat (2) @(negedge HCLK);
    check_outputs("reset");
    HRESETn = 1'b1;
    @(negedge HCLK);
    check_outputs("post_reset");

    // first update with latency check, strobe held high
    bot_update(32'h1234_5678, 1'b0, 1'b0, 1'b1);

    // acknowledge, then a stray ack in IDLE
    ack_pulse();
    ack_pulse();

    // three unacknowledged updates, then clear the overrun
    a = $urandom; b = $urandom; c = $urandom;
    bot_update(a, 1'b0, 1'b0, 1'b1);
    bot_update(b, 1'b0, 1'b0, 1'b0);
    bot_update(c, 1'b0, 1'b0, 1'b0);
    clr_pulse();

    // evt aligned with ack while pending; then evt aligned with clear
    bot_update($urandom, 1'b1, 1'b0, 1'b1);
    bot_update($urandom, 1'b0, 1'b1, 1'b0);
    ack_pulse();

    // randomized mix of updates, acks and clears
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0, 1: bot_update($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        2:    ack_pulse();
        default: clr_pulse();
      endcase
    end

    // counter saturation and wrap: 17 unacknowledged updates after reset
    async_reset(1'b0, 32'h0);
    @(negedge HCLK);
    check_outputs("rel_low");
    for (int i = 0; i < 17; i++) bot_update($urandom, 1'b0, 1'b0, 1'b0);

    // reset mid-pending with Missed_Cnt=5, released with the strobe already high
    async_reset(1'b0, 32'h0);
    for (int i = 0; i < 6; i++) bot_update($urandom, 1'b0, 1'b0, 1'b0);
    a = $urandom;
    async_reset(1'b1, a);
    evt_sequence(a, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
